// File: rtl/imm_gen_pkg.sv
// rtl/imm_gen_pkg.sv - shared opcodes, format codes and pipe entry type for the immediate stage
// Contents: RV32I/RV64I major opcodes, immediate format enum, buffered entry struct.
package imm_gen_pkg;

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_FENCE   = 7'b0001111;

    typedef enum logic [2:0] {
        FMT_NONE,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_SHAMT,
        FMT_Z
    } imm_fmt_e;

    // Entries are sized for the widest legal build; the top narrows on output.
    localparam int IMM_MAX_W = 64;
    localparam int TAG_MAX_W = 32;

    typedef struct packed {
        logic [IMM_MAX_W-1:0] imm;
        imm_fmt_e             fmt;
        logic                 illegal;
        logic [TAG_MAX_W-1:0] tag;
    } imm_entry_t;

endpackage

// File: rtl/imm_decode_comb.sv
// rtl/imm_decode_comb.sv - combinational RISC-V immediate decoder
// Ports: instr_i (instruction word) -> imm_o (XLEN immediate), fmt_o (format), illegal_o (unknown opcode).
module imm_decode_comb
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output imm_fmt_e        fmt_o,
    output logic            illegal_o
);

    logic [6:0]  opc;
    logic [2:0]  funct3;
    logic        sgn;
    logic [63:0] imm64;
    logic [63:0] imm_i;
    logic [63:0] shamt5;
    logic [63:0] shamt6;

    assign opc    = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign sgn    = instr_i[31];
    assign imm_i  = {{52{sgn}}, instr_i[31:20]};
    assign shamt5 = {59'b0, instr_i[24:20]};
    assign shamt6 = {58'b0, instr_i[25:20]};

    // Everything is built at 64 bits and narrowed once; sign-extended
    // values stay correct after truncation to 32.
    always_comb begin
        imm64     = '0;
        fmt_o     = FMT_NONE;
        illegal_o = 1'b0;
        case (opc)
            OPC_LOAD, OPC_JALR: begin
                imm64 = imm_i;
                fmt_o = FMT_I;
            end
            OPC_OPIMM: begin
                // funct3 001/101 are the shifts (SLLI/SRLI/SRAI)
                if (funct3[1:0] == 2'b01) begin
                    imm64 = (XLEN == 64) ? shamt6 : shamt5;
                    fmt_o = FMT_SHAMT;
                end else begin
                    imm64 = imm_i;
                    fmt_o = FMT_I;
                end
            end
            OPC_OPIMM32: begin
                if (XLEN == 64) begin
                    if (funct3[1:0] == 2'b01) begin
                        imm64 = shamt5;
                        fmt_o = FMT_SHAMT;
                    end else begin
                        imm64 = imm_i;
                        fmt_o = FMT_I;
                    end
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OPC_STORE: begin
                imm64 = {{52{sgn}}, instr_i[31:25], instr_i[11:7]};
                fmt_o = FMT_S;
            end
            OPC_BRANCH: begin
                imm64 = {{51{sgn}}, instr_i[31], instr_i[7], instr_i[30:25],
                         instr_i[11:8], 1'b0};
                fmt_o = FMT_B;
            end
            OPC_JAL: begin
                imm64 = {{43{sgn}}, instr_i[31], instr_i[19:12], instr_i[20],
                         instr_i[30:21], 1'b0};
                fmt_o = FMT_J;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm64 = {{32{sgn}}, instr_i[31:12], 12'b0};
                fmt_o = FMT_U;
            end
            OPC_SYSTEM: begin
                // CSR*I forms carry a 5-bit unsigned immediate in the rs1 slot
                if (funct3[2]) begin
                    imm64 = {59'b0, instr_i[19:15]};
                    fmt_o = FMT_Z;
                end
            end
            OPC_OP, OPC_FENCE: begin
                fmt_o = FMT_NONE;
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

    assign imm_o = imm64[XLEN-1:0];

    logic unused_imm_hi;
    assign unused_imm_hi = ^imm64;

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered immediate-generation stage with 2-entry skid buffer
// Ports: clk, reset (sync, active-high), flush (sync kill);
//        in_valid/in_ready/in_instr/in_tag upstream handshake;
//        out_valid/out_ready/out_imm/out_fmt/out_illegal/out_tag downstream handshake.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
    if (TAG_W < 1 || TAG_W > TAG_MAX_W) begin : g_bad_tag
        $error("imm_gen_pipe: TAG_W out of range");
    end

    localparam imm_entry_t ENTRY_CLR = '{imm: '0, fmt: FMT_NONE, illegal: 1'b0, tag: '0};

    logic [XLEN-1:0] dec_imm;
    imm_fmt_e        dec_fmt;
    logic            dec_illegal;
    imm_entry_t      new_entry;

    imm_decode_comb #(.XLEN(XLEN)) u_decode (
        .instr_i   (in_instr),
        .imm_o     (dec_imm),
        .fmt_o     (dec_fmt),
        .illegal_o (dec_illegal)
    );

    imm_entry_t out_q, out_d;
    imm_entry_t skid_q, skid_d;
    logic       out_valid_q, out_valid_d;
    logic       skid_valid_q, skid_valid_d;
    logic       in_fire;
    logic       out_free;

    always_comb begin
        new_entry         = ENTRY_CLR;
        new_entry.imm     = IMM_MAX_W'($signed(dec_imm));
        new_entry.fmt     = dec_fmt;
        new_entry.illegal = dec_illegal;
        new_entry.tag     = TAG_MAX_W'(in_tag);
    end

    // in_ready is a pure flop output, so upstream never sees out_ready combinationally.
    assign in_fire  = in_valid && !skid_valid_q;
    assign out_free = !out_valid_q || out_ready;

    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (out_free) begin
            // A full skid blocks in_ready, so it and in_fire never coincide.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                out_d       = new_entry;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_d       = new_entry;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            out_q        <= ENTRY_CLR;
            skid_q       <= ENTRY_CLR;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign in_ready    = !skid_valid_q;
    assign out_valid   = out_valid_q;
    assign out_imm     = out_q.imm[XLEN-1:0];
    assign out_fmt     = out_q.fmt;
    assign out_illegal = out_q.illegal;
    assign out_tag     = out_q.tag[TAG_W-1:0];

    logic unused_out_hi;
    assign unused_out_hi = ^{out_q.imm, out_q.tag};

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - self-checking bench for imm_gen_pipe at XLEN 32 and 64
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [7:0]  in_tag;

    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_imm32;
    logic [2:0]  out_fmt32;
    logic [7:0]  out_tag32;
    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64;
    logic [2:0]  out_fmt64;
    logic [7:0]  out_tag64;

    imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
        .out_fmt(out_fmt32), .out_illegal(out_illegal32), .out_tag(out_tag32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
        .out_fmt(out_fmt64), .out_illegal(out_illegal64), .out_tag(out_tag64)
    );

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [7:0]  tag;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];

    typedef struct {
        logic [31:0] instr;
        logic [63:0] imm32; logic [2:0] f32; logic i32;
        logic [63:0] imm64; logic [2:0] f64; logic i64;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic longint sext(input longint v, input int w);
        return (v <<< (64 - w)) >>> (64 - w);
    endfunction

    // Reference decode from the ISA field layout, using integer arithmetic.
    function automatic exp_t ref_dec(input logic [31:0] ins, input int xlen, input logic [7:0] tag);
        exp_t   e;
        longint w;
        int     f3;
        w     = longint'({32'd0, ins});
        f3    = int'(ins[14:12]);
        e.tag = tag;
        e.imm = '0;
        e.fmt = FMT_NONE;
        e.ill = 1'b0;
        case (ins[6:0])
            7'h03, 7'h67: begin e.imm = sext((w >> 20) & 64'hFFF, 12); e.fmt = FMT_I; end
            7'h13, 7'h1B: begin
                if (ins[6:0] == 7'h1B && xlen == 32) e.ill = 1'b1;
                else if (f3 == 1 || f3 == 5) begin
                    e.imm = (w >> 20) & ((xlen == 64 && ins[6:0] == 7'h13) ? 63 : 31);
                    e.fmt = FMT_SHAMT;
                end else begin
                    e.imm = sext((w >> 20) & 64'hFFF, 12); e.fmt = FMT_I;
                end
            end
            7'h23: begin
                e.imm = sext((((w >> 25) & 127) * 32) + ((w >> 7) & 31), 12); e.fmt = FMT_S;
            end
            7'h63: begin
                e.imm = sext(((w >> 31) & 1) * 4096 + ((w >> 7) & 1) * 2048 +
                             ((w >> 25) & 63) * 32 + ((w >> 8) & 15) * 2, 13);
                e.fmt = FMT_B;
            end
            7'h6F: begin
                e.imm = sext(((w >> 31) & 1) * 1048576 + ((w >> 12) & 255) * 4096 +
                             ((w >> 20) & 1) * 2048 + ((w >> 21) & 1023) * 2, 21);
                e.fmt = FMT_J;
            end
            7'h37, 7'h17: begin e.imm = sext(w & 64'hFFFFF000, 32); e.fmt = FMT_U; end
            7'h73: if (f3 >= 4) begin e.imm = (w >> 15) & 31; e.fmt = FMT_Z; end
            7'h33, 7'h0F: e.fmt = FMT_NONE;
            default: e.ill = 1'b1;
        endcase
        if (xlen == 32) e.imm = e.imm & 64'hFFFF_FFFF;
        return e;
    endfunction

    // One clock: check outputs against the FIFO model, update it, advance to next negedge.
    task automatic tick();
        bit room;
        room = (q32.size() < 2);
        chk("in_ready32", in_ready32, room);
        chk("in_ready64", in_ready64, room);
        chk("out_valid32", out_valid32, q32.size() > 0);
        chk("out_valid64", out_valid64, q64.size() > 0);
        if (q32.size() > 0) begin
            chk("imm32", out_imm32, q32[0].imm);
            chk("fmt32", out_fmt32, q32[0].fmt);
            chk("ill32", out_illegal32, q32[0].ill);
            chk("tag32", out_tag32, q32[0].tag);
            chk("imm64", out_imm64, q64[0].imm);
            chk("fmt64", out_fmt64, q64[0].fmt);
            chk("ill64", out_illegal64, q64[0].ill);
            chk("tag64", out_tag64, q64[0].tag);
        end
        if (reset || flush) begin
            q32.delete();
            q64.delete();
        end else begin
            if (out_ready && q32.size() > 0) begin
                void'(q32.pop_front());
                void'(q64.pop_front());
            end
            if (in_valid && room) begin
                q32.push_back(ref_dec(in_instr, 32, in_tag));
                q64.push_back(ref_dec(in_instr, 64, in_tag));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t tbl[15];
    logic [6:0] opc_pool[13] = '{7'h03, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h6F, 7'h67,
                                 7'h37, 7'h17, 7'h73, 7'h33, 7'h0F, 7'h7F};

    initial begin
        int t, ntag, first_c, last_c;
        bit acc;
        logic [31:0] r;
        logic [6:0]  opc;
        int          idx;

        tbl[0]  = '{32'hFFF00093, 64'hFFFFFFFF, FMT_I, 1'b0, 64'hFFFFFFFFFFFFFFFF, FMT_I, 1'b0};
        tbl[1]  = '{32'hFE000EE3, 64'hFFFFFFFC, FMT_B, 1'b0, 64'hFFFFFFFFFFFFFFFC, FMT_B, 1'b0};
        tbl[2]  = '{32'h001000EF, 64'h00000800, FMT_J, 1'b0, 64'h0000000000000800, FMT_J, 1'b0};
        tbl[3]  = '{32'h123452B7, 64'h12345000, FMT_U, 1'b0, 64'h0000000012345000, FMT_U, 1'b0};
        tbl[4]  = '{32'h01F09093, 64'h0000001F, FMT_SHAMT, 1'b0, 64'h1F, FMT_SHAMT, 1'b0};
        tbl[5]  = '{32'h0000007F, 64'h0, FMT_NONE, 1'b1, 64'h0, FMT_NONE, 1'b1};
        tbl[6]  = '{32'hFFF0009B, 64'h0, FMT_NONE, 1'b1, 64'hFFFFFFFFFFFFFFFF, FMT_I, 1'b0};
        tbl[7]  = '{32'hFE20AC23, 64'hFFFFFFF8, FMT_S, 1'b0, 64'hFFFFFFFFFFFFFFF8, FMT_S, 1'b0};
        tbl[8]  = '{32'h3002D073, 64'h5, FMT_Z, 1'b0, 64'h5, FMT_Z, 1'b0};
        tbl[9]  = '{32'h00000073, 64'h0, FMT_NONE, 1'b0, 64'h0, FMT_NONE, 1'b0};
        tbl[10] = '{32'h00000033, 64'h0, FMT_NONE, 1'b0, 64'h0, FMT_NONE, 1'b0};
        tbl[11] = '{32'h0FF0000F, 64'h0, FMT_NONE, 1'b0, 64'h0, FMT_NONE, 1'b0};
        tbl[12] = '{32'h4210D093, 64'h1, FMT_SHAMT, 1'b0, 64'h21, FMT_SHAMT, 1'b0};
        tbl[13] = '{32'h80010067, 64'hFFFFF800, FMT_I, 1'b0, 64'hFFFFFFFFFFFFF800, FMT_I, 1'b0};
        tbl[14] = '{32'hFFFFF017, 64'hFFFFF000, FMT_U, 1'b0, 64'hFFFFFFFFFFFFF000, FMT_U, 1'b0};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_tag = '0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("rst_out_valid", out_valid32, 1'b0);
        chk("rst_in_ready", in_ready32, 1'b1);
        chk("rst_imm32", out_imm32, 64'h0);
        chk("rst_imm64", out_imm64, 64'h0);
        chk("rst_fmt", out_fmt32, FMT_NONE);
        chk("rst_ill", out_illegal32, 1'b0);
        chk("rst_tag", out_tag32, 8'h0);

        // Directed decode table, streamed back to back with 1-cycle latency
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            in_valid = 1'b1; in_instr = tbl[i].instr; in_tag = 8'(i);
            tick();
            in_valid = 1'b0;
            chk("tbl_valid", out_valid32, 1'b1);
            chk("tbl_imm32", out_imm32, tbl[i].imm32);
            chk("tbl_fmt32", out_fmt32, tbl[i].f32);
            chk("tbl_ill32", out_illegal32, tbl[i].i32);
            chk("tbl_tag32", out_tag32, 8'(i));
            chk("tbl_imm64", out_imm64, tbl[i].imm64);
            chk("tbl_fmt64", out_fmt64, tbl[i].f64);
            chk("tbl_ill64", out_illegal64, tbl[i].i64);
        end
        tick();

        // Backpressure: 4 instructions, out_ready low for the first 3 cycles
        t = 0; ntag = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 10; c++) begin
            out_ready = (c >= 3);
            in_valid  = (t < 4);
            in_tag    = 8'(t);
            in_instr  = 32'h00000093 | (32'(t) << 20);
            if (c == 2) chk("bp_in_ready_low", in_ready32, 1'b0);
            if (out_valid32 && out_ready) begin
                chk("bp_order", out_tag32, 8'(ntag));
                if (first_c < 0) first_c = c;
                last_c = c;
                ntag++;
            end
            acc = in_valid && in_ready32;
            tick();
            if (acc) t++;
        end
        in_valid = 1'b0;
        chk("bp_count", 64'(ntag), 64'd4);
        chk("bp_throughput", 64'(last_c - first_c), 64'd3);

        // Flush with output and skid full plus a new input
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 32'hFFF00093; in_tag = 8'd10; tick();
        in_tag = 8'd11; tick();
        chk("fl_in_ready_full", in_ready32, 1'b0);
        in_tag = 8'd12; flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_out_valid", out_valid32, 1'b0);
        chk("fl_in_ready", in_ready32, 1'b1);
        out_ready = 1'b1; tick();
        chk("fl_no_ghost", out_valid32, 1'b0);

        // Reset in the middle of a stall
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 32'hFE000EE3; in_tag = 8'd20; tick();
        in_tag = 8'd21; tick();
        reset = 1'b1; tick();
        reset = 1'b0; in_valid = 1'b0;
        chk("rs_out_valid", out_valid32, 1'b0);
        chk("rs_imm", out_imm32, 64'h0);
        chk("rs_fmt", out_fmt32, FMT_NONE);
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 8'h55;
        tick();
        in_valid = 1'b0;
        chk("rs_first_valid", out_valid32, 1'b1);
        chk("rs_first_imm", out_imm32, 64'hFFFFFFFF);
        chk("rs_first_tag", out_tag32, 8'h55);
        tick();

        // Randomized traffic against the FIFO model
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 99) < 2);
            reset     = ($urandom_range(0, 199) == 0);
            r   = $urandom;
            idx = $urandom_range(0, 13);
            opc = (idx == 13) ? r[6:0] : opc_pool[idx];
            in_instr = {r[31:7], opc};
            in_tag   = 8'($urandom);
            tick();
        end
        in_valid = 1'b0; flush = 1'b0; reset = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Registered, parametrised immediate-generation stage for the RISC-V decode path.
- Accepts one 32-bit instruction per cycle over a valid/ready handshake.
- Decodes the immediate for every RV32I/RV64I format, sign-extended to XLEN, and reports the format and an illegal-opcode flag.
- Sits between fetch and register-read; a 2-entry skid buffer keeps full throughput under backpressure, and a flush port supports branch redirect.

Parameters:
- XLEN, 32, datapath width. Legal values are 32 or 64; any other value is an elaboration error.
- TAG_W, 8, width of the opaque tag (PC index or ROB id) passed through alongside the instruction.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous pipeline kill; same effect as reset on the buffer.
- in_valid  in  1  instruction offered.
- in_ready  out  1  stage can accept.
- in_instr  in  32  instruction word.
- in_tag  in  TAG_W  passthrough tag.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts.
- out_imm  out  XLEN  decoded immediate.
- out_fmt  out  3  immediate format code (package enum).
- out_illegal  out  1  opcode not recognised for this XLEN.
- out_tag  out  TAG_W  tag of the output entry.

Behaviour:
- Handshake: transfer occurs when valid&&ready on the same edge. out_valid is never dropped until accepted. Output payload is stable while out_valid&&!out_ready.
- Latency: exactly 1 cycle from input accept to out_valid when not back-pressured.
- Storage: main output register plus one skid register. in_ready = !skid_valid, driven from a flop with no combinational path from out_ready.
- Stall sequence: output full and stalled, new input accepted → input goes to skid and in_ready falls next cycle. On output accept, skid moves to output in the same edge.
- Ordering is strictly FIFO.
- Decode by opcode in_instr[6:0]; every result is sign-extended from in_instr[31] to XLEN unless stated otherwise:
  - 0000011 LOAD, 0010011 OP-IMM, 1100111 JALR: fmt I, imm = instr[31:20].
  - OP-IMM with funct3 001/101: fmt SHAMT, imm = zero-extended instr[24:20] for XLEN=32, instr[25:20] for XLEN=64.
  - 0100011 STORE: fmt S, imm = {instr[31:25], instr[11:7]}.
  - 1100011 BRANCH: fmt B, imm = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}. The result is a byte offset with LSB 0.
  - 1101111 JAL: fmt J, imm = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - 0110111 LUI, 0010111 AUIPC: fmt U, imm = {instr[31:12], 12'b0} sign-extended.
  - 1110011 SYSTEM with funct3[2]=1: fmt Z, imm = zero-extended instr[19:15]. Other SYSTEM encodings: fmt NONE, imm 0, legal.
  - 0110011 OP, 0001111 FENCE: fmt NONE, imm 0, legal.
  - 0011011 OP-IMM-32: legal only when XLEN=64 (I/SHAMT rules, 5-bit shamt). Illegal when XLEN=32.
  - Any other opcode: fmt NONE, imm 0, out_illegal=1. The entry still flows through the pipe; it is not dropped.
- Reset (synchronous, active-high) and flush:
  - Next edge clears both valid bits.
  - out_imm, out_tag = 0; out_fmt = NONE; out_illegal = 0.
  - in_ready = 1 from the first cycle after reset deasserts.
- Flush takes priority over an in_valid presented in the same cycle; that input is discarded.
- Reset mid-stall discards buffered entries with no output handshake.
- Simultaneous output accept and input accept with the skid empty: the output register loads the new entry and out_valid stays 1 (full throughput).

Decomposition:
- Package imm_gen_pkg holds:
  - opcode localparams: OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_SYSTEM, OPC_OP, OPC_FENCE;
  - typedef enum logic[2:0] imm_fmt_e {FMT_NONE, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SHAMT, FMT_Z};
  - packed struct imm_entry_t {imm, fmt, illegal, tag}.
- Sub-module imm_decode_comb: purely combinational, XLEN-parametrised, instr → imm/fmt/illegal. The top holds the handshake and skid logic only.

Test Plan:
- XLEN=32, 0xFFF00093 (addi x1,x0,-1) → next cycle out_imm=0xFFFFFFFF, fmt=I, illegal=0.
- 0xFE000EE3 (beq x0,x0,-4) → out_imm=0xFFFFFFFC, fmt=B. Then 0x001000EF (jal x1,+2048) → out_imm=0x00000800, fmt=J.
- 0x123452B7 (lui x5,0x12345) → out_imm=0x12345000 (XLEN=64: 0x0000000012345000). 0x01F09093 (slli x1,x1,31) → out_imm=0x1F, fmt=SHAMT. Opcode 0x7F → imm 0, illegal=1.
- Backpressure: stream 4 instructions with out_ready=0 for 3 cycles → in_ready falls after 2 accepts. No loss or duplication; tags emerge in order 0,1,2,3. Once unstalled, 1 result/cycle.
- Flush with output and skid both full plus in_valid=1 → next cycle out_valid=0, in_ready=1; the flushed-cycle input never appears.
- Reset asserted mid-stall → next cycle out_valid=0, out_imm=0, fmt=NONE. The first post-reset instruction emerges with 1-cycle latency.
